vh_result_checker: RTL and testbench
====================================

// Module: vh_result_checker
// PURPOSE
//  Drives one stimulus vector at a time into a combinational expression-test module.
//  After a fixed settle time it samples the module's output and compares it with an
//  expected value under a don't-care mask. Mask bits mark positions the expected
//  value leaves undefined (e.g. 4'b000x: only bit 0 is don't-care).
//  It is the consumer end of the issue_* test modules: they produce y, this block
//  judges y and keeps pass/fail statistics for the regression harness.
// PARAMETERS
//  WA      8   width of the stimulus bus driven to the module under test (dut_a)
//  WY      32  width of the module-under-test result bus (dut_y)
//  SETTLE  2   cycles between driving dut_a and sampling dut_y (legal range 1..15)
//  CW      16  width of the vector index and mismatch counters
// PORTS
//  clk        in   1   single clock; all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   pulse: clear counters and begin a run (ignored unless IDLE or DONE)
//  vec_valid  in   1   vector available on vec_a/vec_exp/vec_xmask
//  vec_ready  out  1   block accepts a vector this cycle
//  vec_last   in   1   qualifies the accepted vector as the final one of the run
//  vec_a      in   WA  stimulus value for dut_a
//  vec_exp    in   WY  expected dut_y value (bits under vec_xmask are ignored)
//  vec_xmask  in   WY  1 = expected bit is undefined/don't-care
//  dut_a      out  WA  stimulus to the module under test
//  dut_y      in   WY  result from the module under test
//  res_valid  out  1   one-cycle pulse: comparison result for one vector
//  res_fail   out  1   with res_valid: 1 = mismatch on a cared bit
//  res_diff   out  WY  with res_valid: (dut_y ^ exp) & ~xmask
//  vec_count  out  CW  vectors checked so far this run
//  fail_count out  CW  mismatching vectors so far this run (saturates at all-ones)
//  first_fail out  CW  index of the first failing vector; all-ones if none
//  done       out  1   run complete; held until next start or rst
// BEHAVIOUR
//  Reset (rst=1 at a clock edge) clears every register:
//   state=IDLE; vec_ready=0; dut_a=0; res_valid=0; res_fail=0; res_diff=0;
//   vec_count=0; fail_count=0; first_fail=all-ones; done=0.
//   Reset mid-run abandons the current vector and produces no res_valid.
//  FSM states: IDLE, FETCH, SETTLE, CHECK, DONE.
//   IDLE: start -> FETCH. Counters are cleared, first_fail=all-ones, done=0.
//   FETCH: vec_ready=1. On vec_valid&&vec_ready, register vec_a into dut_a and
//     register exp, xmask and last; go to SETTLE with wait counter = SETTLE-1.
//     vec_ready is 1 only in FETCH (at most one vector in flight).
//   SETTLE: decrement the wait counter; go to CHECK when it reaches 0.
//     Result: dut_a is stable for exactly SETTLE cycles before dut_y is sampled.
//   CHECK: one cycle. Compute diff=(dut_y^exp)&~xmask and pulse res_valid.
//     res_fail=|diff. vec_count+=1. On fail: fail_count+=1 (saturating).
//     If fail_count was 0, first_fail=vec_count (pre-increment value).
//     Next state: DONE if last, else FETCH.
//   DONE: done=1; dut_a holds the last stimulus. start -> same actions as from IDLE.
//  res_valid, res_fail and res_diff are registered outputs, valid in the cycle after
//   CHECK. res_diff holds its value between pulses; res_fail is 0 when res_valid=0.
//  Latency from vector accept to res_valid is SETTLE+2 cycles.
//  start during FETCH, SETTLE or CHECK is ignored; the run is never restarted implicitly.
//  An all-ones xmask always passes. A zero xmask requires an exact match on every bit.
//  vec_count wraps at 2^CW; the wrapped index is still reported as first_fail.
//  Purely 2-state compare: undefined expectations are expressed only via vec_xmask.
// TESTING
//  1 Run of 1 vector: a=3, exp=5, xmask=0, dut_y=5 -> res_valid at accept+SETTLE+2,
//    res_fail=0, done=1, vec_count=1, first_fail=all-ones.
//  2 exp=4'b0000, xmask=4'b0001, dut_y=4'b0001 -> pass.
//    Same with dut_y=4'b0011 -> fail, res_diff=4'b0010.
//  3 Run of 5 vectors, vectors 2 and 4 wrong -> fail_count=2, first_fail=2, vec_count=5.
//  4 vec_valid dropped for 3 cycles in FETCH -> vec_ready stays 1, no res_valid;
//    resumes correctly afterwards.
//  5 rst asserted during SETTLE -> no res_valid; all outputs at reset values next cycle.
//  6 start pulsed during SETTLE -> ignored. start in DONE -> counters cleared, new run passes.

Source files
------------

// File: rtl/vh_result_checker_if.sv
// Signal bundle between the result checker and whoever feeds it vectors
// and hosts the module under test.
interface vh_result_checker_if #(
  parameter int WA = 8,
  parameter int WY = 32,
  parameter int CW = 16
);
  logic          start;
  logic          vec_valid;
  logic          vec_ready;
  logic          vec_last;
  logic [WA-1:0] vec_a;
  logic [WY-1:0] vec_exp;
  logic [WY-1:0] vec_xmask;
  logic [WA-1:0] dut_a;
  logic [WY-1:0] dut_y;
  logic          res_valid;
  logic          res_fail;
  logic [WY-1:0] res_diff;
  logic [CW-1:0] vec_count;
  logic [CW-1:0] fail_count;
  logic [CW-1:0] first_fail;
  logic          done;

  modport slave (
    input  start, vec_valid, vec_last, vec_a, vec_exp, vec_xmask, dut_y,
    output vec_ready, dut_a, res_valid, res_fail, res_diff,
           vec_count, fail_count, first_fail, done
  );

  modport master (
    output start, vec_valid, vec_last, vec_a, vec_exp, vec_xmask, dut_y,
    input  vec_ready, dut_a, res_valid, res_fail, res_diff,
           vec_count, fail_count, first_fail, done
  );
endinterface

// File: rtl/vh_result_checker.sv
// Drives one stimulus vector into a combinational module under test, waits a
// fixed settle time, then compares its result against a masked expectation.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | after reset, waiting for start
// ST_FETCH  | vec_ready=1, waiting for the next vector
// ST_SETTLE | dut_a driven, counting down the settle time
// ST_CHECK  | sample dut_y, compare, update statistics
// ST_DONE   | run complete, done=1 until the next start
module vh_result_checker #(
  parameter int WA     = 8,
  parameter int WY     = 32,
  parameter int SETTLE = 2,
  parameter int CW     = 16
) (
  input logic              clk,
  input logic              rst,
  vh_result_checker_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [3:0]    WAIT_INIT = 4'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t        state_q, state_d;
  logic [3:0]    wait_q, wait_d;
  logic [WA-1:0] dut_a_q, dut_a_d;
  logic [WY-1:0] exp_q, exp_d;
  logic [WY-1:0] xmask_q, xmask_d;
  logic          last_q, last_d;
  logic          res_valid_q, res_valid_d;
  logic          res_fail_q, res_fail_d;
  logic [WY-1:0] res_diff_q, res_diff_d;
  logic [CW-1:0] vec_count_q, vec_count_d;
  logic [CW-1:0] fail_count_q, fail_count_d;
  logic [CW-1:0] first_fail_q, first_fail_d;
  logic          done_q, done_d;
  logic [WY-1:0] diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      dut_a_q      <= '0;
      exp_q        <= '0;
      xmask_q      <= '0;
      last_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_fail_q   <= 1'b0;
      res_diff_q   <= '0;
      vec_count_q  <= '0;
      fail_count_q <= '0;
      first_fail_q <= '1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      dut_a_q      <= dut_a_d;
      exp_q        <= exp_d;
      xmask_q      <= xmask_d;
      last_q       <= last_d;
      res_valid_q  <= res_valid_d;
      res_fail_q   <= res_fail_d;
      res_diff_q   <= res_diff_d;
      vec_count_q  <= vec_count_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    dut_a_d      = dut_a_q;
    exp_d        = exp_q;
    xmask_d      = xmask_q;
    last_d       = last_q;
    res_valid_d  = 1'b0;
    res_fail_d   = 1'b0;
    res_diff_d   = res_diff_q;
    vec_count_d  = vec_count_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    done_d       = done_q;
    diff         = (bus.dut_y ^ exp_q) & ~xmask_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d      = ST_FETCH;
          vec_count_d  = '0;
          fail_count_d = '0;
          first_fail_d = '1;
          done_d       = 1'b0;
        end
      end
      ST_FETCH: begin
        if (bus.vec_valid) begin
          dut_a_d = bus.vec_a;
          exp_d   = bus.vec_exp;
          xmask_d = bus.vec_xmask;
          last_d  = bus.vec_last;
          wait_d  = WAIT_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (wait_q == '0) state_d = ST_CHECK;
        else              wait_d  = wait_q - 4'd1;
      end
      ST_CHECK: begin
        res_valid_d = 1'b1;
        res_fail_d  = |diff;
        res_diff_d  = diff;
        vec_count_d = vec_count_q + CNT_ONE;
        // first_fail keys off the pre-update fail count; saturation keeps it nonzero
        if (|diff) begin
          if (fail_count_q != '1) fail_count_d = fail_count_q + CNT_ONE;
          if (fail_count_q == '0) first_fail_d = vec_count_q;
        end
        state_d = last_q ? ST_DONE : ST_FETCH;
        done_d  = last_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.vec_ready  = (state_q == ST_FETCH);
  assign bus.dut_a      = dut_a_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_fail   = res_fail_q;
  assign bus.res_diff   = res_diff_q;
  assign bus.vec_count  = vec_count_q;
  assign bus.fail_count = fail_count_q;
  assign bus.first_fail = first_fail_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_vh_result_checker.sv
// Self-checking bench for vh_result_checker: directed scenarios plus a random
// run, compared against a counter-level reference model of the run statistics.
module tb_vh_result_checker;
  localparam int WA     = 8;
  localparam int WY     = 32;
  localparam int SETTLE = 2;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;
  localparam int LAT    = SETTLE + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  int m_vecs, m_fails, m_first;

  vh_result_checker_if #(.WA(WA), .WY(WY), .CW(CW)) vif ();

  vh_result_checker #(.WA(WA), .WY(WY), .SETTLE(SETTLE), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  always #5 clk = ~clk;

  // reference model: run statistics in plain integers, reduced to CW bits on demand
  function automatic void model_start();
    m_vecs  = 0;
    m_fails = 0;
    m_first = -1;
  endfunction

  function automatic logic [WY-1:0] model_vec(input logic [WY-1:0] e, input logic [WY-1:0] m,
                                              input logic [WY-1:0] y);
    logic [WY-1:0] d;
    d = (y ^ e) & ~m;
    if (d != 0) begin
      if (m_first < 0) m_first = m_vecs;
      m_fails++;
    end
    m_vecs++;
    return d;
  endfunction

  function automatic logic [CW-1:0] exp_vc();
    return CW'(m_vecs % (CMAX + 1));
  endfunction

  function automatic logic [CW-1:0] exp_fc();
    return CW'((m_fails > CMAX) ? CMAX : m_fails);
  endfunction

  function automatic logic [CW-1:0] exp_ff();
    return CW'((m_first < 0) ? CMAX : (m_first % (CMAX + 1)));
  endfunction

  task automatic pulse_start();
    vif.start = 1'b1;
    @(negedge clk);
    vif.start = 1'b0;
  endtask

  // drives one vector; returns accept-to-result latency (-1 if never accepted)
  task automatic send_vec(input logic [WA-1:0] a, input logic [WY-1:0] e, input logic [WY-1:0] m,
                          input logic [WY-1:0] y, input logic last, input logic poke_start,
                          output int lat, output logic got_fail, output logic [WY-1:0] got_diff,
                          output logic [WA-1:0] got_a);
    int w;
    w = 0;
    lat = -1;
    got_fail = 1'b0;
    got_diff = '0;
    got_a = '0;
    while (!vif.vec_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!vif.vec_ready) return;
    vif.vec_valid = 1'b1;
    vif.vec_a     = a;
    vif.vec_exp   = e;
    vif.vec_xmask = m;
    vif.vec_last  = last;
    @(negedge clk);
    vif.vec_valid = 1'b0;
    vif.dut_y     = y;
    got_a         = vif.dut_a;
    if (poke_start) vif.start = 1'b1;
    lat = 1;
    while (!vif.res_valid && lat < 40) begin
      @(negedge clk);
      vif.start = 1'b0;
      lat++;
    end
    vif.start = 1'b0;
    got_fail = vif.res_fail;
    got_diff = vif.res_diff;
  endtask

  task automatic test_reset();
    logic [55:0] got, want;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    got  = {vif.vec_ready, vif.dut_a, vif.res_valid, vif.res_fail, vif.res_diff,
            vif.vec_count, vif.fail_count, vif.first_fail, vif.done};
    want = {1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 4'hF, 1'b0};
    checks++;
    if (got !== want) $display("FAIL reset_state: got %h want %h", got, want);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int lat; logic f; logic [WY-1:0] d; logic [WA-1:0] a;
    pulse_start();
    model_start();
    send_vec(8'd3, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0, lat, f, d, a);
    void'(model_vec(32'd5, 32'd0, 32'd5));
    checks++;
    if (lat !== LAT) $display("FAIL single_latency: got %0d want %0d", lat, LAT);
    else passes++;
    checks++;
    if (a !== 8'd3) $display("FAIL single_dut_a: got %0d want 3", a);
    else passes++;
    checks++;
    if (f !== 1'b0) $display("FAIL single_res_fail: got %b want 0", f);
    else passes++;
    checks++;
    if (vif.done !== 1'b1) $display("FAIL single_done: got %b want 1", vif.done);
    else passes++;
    checks++;
    if ({vif.vec_count, vif.first_fail} !== {exp_vc(), exp_ff()})
      $display("FAIL single_counts: got vc=%0d ff=%0d want vc=%0d ff=%0d",
               vif.vec_count, vif.first_fail, exp_vc(), exp_ff());
    else passes++;
  endtask

  task automatic test_mask();
    int lat; logic f; logic [WY-1:0] d, md; logic [WA-1:0] a;
    pulse_start();
    model_start();
    send_vec(8'd1, 32'h0, 32'h1, 32'h1, 1'b0, 1'b0, lat, f, d, a);
    md = model_vec(32'h0, 32'h1, 32'h1);
    checks++;
    if (f !== (md != 0)) $display("FAIL mask_pass: got fail=%b want %b", f, (md != 0));
    else passes++;
    send_vec(8'd2, 32'h0, 32'h1, 32'h3, 1'b1, 1'b0, lat, f, d, a);
    md = model_vec(32'h0, 32'h1, 32'h3);
    checks++;
    if ({f, d} !== {1'b1, md} || md !== 32'h2)
      $display("FAIL mask_fail: got fail=%b diff=%h want fail=1 diff=%h", f, d, md);
    else passes++;
  endtask

  task automatic test_five();
    int lat; logic f; logic [WY-1:0] d, md, y, e; logic [WA-1:0] a;
    int bad;
    pulse_start();
    model_start();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      e = $urandom;
      y = (i == 2 || i == 4) ? (e ^ 32'h0001_0000) : e;
      send_vec(WA'(i), e, 32'h0, y, (i == 4), 1'b0, lat, f, d, a);
      md = model_vec(e, 32'h0, y);
      if (f !== (md != 0) || d !== md) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL five_results: %0d of 5 vectors reported wrong, want 0", bad);
    else passes++;
    checks++;
    if ({vif.vec_count, vif.fail_count, vif.first_fail} !== {4'd5, 4'd2, 4'd2})
      $display("FAIL five_counts: got vc=%0d fc=%0d ff=%0d want vc=5 fc=2 ff=2",
               vif.vec_count, vif.fail_count, vif.first_fail);
    else passes++;
  endtask

  task automatic test_stall();
    int lat, bad; logic f; logic [WY-1:0] d; logic [WA-1:0] a;
    pulse_start();
    model_start();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (vif.vec_ready !== 1'b1 || vif.res_valid !== 1'b0 || vif.res_fail !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) $display("FAIL stall_idle: %0d bad cycles, want 0", bad);
    else passes++;
    send_vec(8'hA5, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, lat, f, d, a);
    void'(model_vec(32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF));
    checks++;
    if ({lat, f, a, vif.vec_count} !== {LAT, 1'b0, 8'hA5, exp_vc()})
      $display("FAIL stall_resume: got lat=%0d fail=%b a=%h vc=%0d want lat=%0d fail=0 a=a5 vc=%0d",
               lat, f, a, vif.vec_count, LAT, exp_vc());
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [55:0] got, want;
    int w, seen;
    pulse_start();
    w = 0;
    while (!vif.vec_ready && w < 20) begin @(negedge clk); w++; end
    vif.vec_valid = 1'b1;
    vif.vec_a     = 8'h5C;
    vif.vec_exp   = 32'h1;
    vif.vec_xmask = 32'h0;
    vif.vec_last  = 1'b1;
    @(negedge clk);
    vif.vec_valid = 1'b0;
    vif.dut_y     = 32'h2;
    rst = 1'b1;
    @(negedge clk);
    got  = {vif.vec_ready, vif.dut_a, vif.res_valid, vif.res_fail, vif.res_diff,
            vif.vec_count, vif.fail_count, vif.first_fail, vif.done};
    want = {1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 4'hF, 1'b0};
    checks++;
    if (got !== want) $display("FAIL reset_mid_state: got %h want %h", got, want);
    else passes++;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vif.res_valid) seen++;
    end
    checks++;
    if (seen != 0 || vif.vec_ready !== 1'b0)
      $display("FAIL reset_mid_quiet: got %0d res_valid pulses ready=%b want 0 and 0", seen, vif.vec_ready);
    else passes++;
  endtask

  task automatic test_start_ignored();
    int lat; logic f; logic [WY-1:0] d; logic [WA-1:0] a;
    pulse_start();
    model_start();
    send_vec(8'd1, 32'h10, 32'h0, 32'h11, 1'b0, 1'b0, lat, f, d, a);
    void'(model_vec(32'h10, 32'h0, 32'h11));
    send_vec(8'd2, 32'h20, 32'h0, 32'h20, 1'b0, 1'b1, lat, f, d, a);
    void'(model_vec(32'h20, 32'h0, 32'h20));
    checks++;
    if ({vif.vec_count, vif.fail_count, vif.first_fail, vif.vec_ready} !==
        {exp_vc(), exp_fc(), exp_ff(), 1'b1})
      $display("FAIL start_in_settle: got vc=%0d fc=%0d ff=%0d rdy=%b want vc=%0d fc=%0d ff=%0d rdy=1",
               vif.vec_count, vif.fail_count, vif.first_fail, vif.vec_ready,
               exp_vc(), exp_fc(), exp_ff());
    else passes++;
    send_vec(8'd3, 32'h30, 32'h0, 32'h30, 1'b1, 1'b0, lat, f, d, a);
    void'(model_vec(32'h30, 32'h0, 32'h30));
    checks++;
    if ({vif.done, vif.vec_count} !== {1'b1, exp_vc()})
      $display("FAIL run_end: got done=%b vc=%0d want done=1 vc=%0d", vif.done, vif.vec_count, exp_vc());
    else passes++;
    pulse_start();
    model_start();
    checks++;
    if ({vif.done, vif.vec_count, vif.fail_count, vif.first_fail} !== {1'b0, 4'd0, 4'd0, 4'hF})
      $display("FAIL restart_clear: got done=%b vc=%0d fc=%0d ff=%0d want 0 0 0 15",
               vif.done, vif.vec_count, vif.fail_count, vif.first_fail);
    else passes++;
    send_vec(8'd4, 32'h44, 32'h0, 32'h44, 1'b1, 1'b0, lat, f, d, a);
    void'(model_vec(32'h44, 32'h0, 32'h44));
    checks++;
    if ({f, vif.done, vif.vec_count, vif.fail_count} !== {1'b0, 1'b1, exp_vc(), exp_fc()})
      $display("FAIL restart_run: got fail=%b done=%b vc=%0d fc=%0d want 0 1 %0d %0d",
               f, vif.done, vif.vec_count, vif.fail_count, exp_vc(), exp_fc());
    else passes++;
  endtask

  task automatic test_saturate_wrap();
    int lat; logic f; logic [WY-1:0] d, e; logic [WA-1:0] a;
    pulse_start();
    model_start();
    for (int i = 0; i < 18; i++) begin
      e = $urandom;
      send_vec(WA'(i), e, 32'h0, ~e, (i == 17), 1'b0, lat, f, d, a);
      void'(model_vec(e, 32'h0, ~e));
    end
    checks++;
    if ({vif.vec_count, vif.fail_count, vif.first_fail} !== {exp_vc(), exp_fc(), exp_ff()})
      $display("FAIL saturate: got vc=%0d fc=%0d ff=%0d want vc=%0d fc=%0d ff=%0d",
               vif.vec_count, vif.fail_count, vif.first_fail, exp_vc(), exp_fc(), exp_ff());
    else passes++;
    pulse_start();
    model_start();
    for (int i = 0; i < 18; i++) begin
      e = $urandom;
      send_vec(WA'(i), e, 32'h0, (i == 17) ? (e ^ 32'h8000_0000) : e, (i == 17), 1'b0, lat, f, d, a);
      void'(model_vec(e, 32'h0, (i == 17) ? (e ^ 32'h8000_0000) : e));
    end
    checks++;
    if ({vif.vec_count, vif.fail_count, vif.first_fail} !== {exp_vc(), exp_fc(), exp_ff()})
      $display("FAIL wrap_first_fail: got vc=%0d fc=%0d ff=%0d want vc=%0d fc=%0d ff=%0d",
               vif.vec_count, vif.fail_count, vif.first_fail, exp_vc(), exp_fc(), exp_ff());
    else passes++;
  endtask

  task automatic test_random();
    int lat, bad; logic f; logic [WY-1:0] d, md, e, m, y; logic [WA-1:0] a, va;
    pulse_start();
    model_start();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      va = WA'($urandom);
      e  = $urandom;
      case ($urandom_range(0, 2))
        0:       m = '0;
        1:       m = '1;
        default: m = $urandom;
      endcase
      case ($urandom_range(0, 2))
        0:       y = e;
        1:       y = e ^ ($urandom & m);
        default: y = e ^ (32'h1 << $urandom_range(0, WY - 1));
      endcase
      send_vec(va, e, m, y, (i == 39), 1'b0, lat, f, d, a);
      md = model_vec(e, m, y);
      if (lat != LAT || a !== va || f !== (md != 0) || d !== md) begin
        bad++;
        if (bad <= 3)
          $display("  vector %0d: lat=%0d a=%h fail=%b diff=%h expected a=%h fail=%b diff=%h",
                   i, lat, a, f, d, va, (md != 0), md);
      end
    end
    checks++;
    if (bad != 0) $display("FAIL random_vectors: got %0d bad vectors want 0", bad);
    else passes++;
    checks++;
    if ({vif.done, vif.vec_count, vif.fail_count, vif.first_fail} !== {1'b1, exp_vc(), exp_fc(), exp_ff()})
      $display("FAIL random_counts: got done=%b vc=%0d fc=%0d ff=%0d want 1 %0d %0d %0d",
               vif.done, vif.vec_count, vif.fail_count, vif.first_fail, exp_vc(), exp_fc(), exp_ff());
    else passes++;
  endtask

  initial begin
    vif.start     = 1'b0;
    vif.vec_valid = 1'b0;
    vif.vec_last  = 1'b0;
    vif.vec_a     = '0;
    vif.vec_exp   = '0;
    vif.vec_xmask = '0;
    vif.dut_y     = '0;
    model_start();
    @(negedge clk);
    test_reset();
    test_single();
    test_mask();
    test_five();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    test_saturate_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1);
  end
endmodule
